// File: rtl/alu_mul_seq_pkg.sv
// ----------------------------------------------------------------------------
// alu_mul_seq_pkg
// Shared constants and types for the sequential shift-add multiplier that
// borrows the datapath's 32-bit ALU.
//   DATA_LEN      : datapath / ALU width
//   ALU_OPCODE_W  : width of the ALU opcode bus
//   ALU_ADD       : opcode that makes the shared ALU return a + b
//   mul_state_t   : controller states (IDLE=0, RUN=1, DONE=2)
// ----------------------------------------------------------------------------
package alu_mul_seq_pkg;

  localparam int DATA_LEN     = 32;
  localparam int ALU_OPCODE_W = 4;

  typedef logic [ALU_OPCODE_W-1:0] alu_opcode_t;

  localparam alu_opcode_t ALU_ADD = 4'd0;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// ----------------------------------------------------------------------------
// alu_mul_seq_if
// Bundles the multiplier request/result handshake with the shared-ALU request
// bus.
//   start, op_a, op_b      : request from the datapath
//   busy, done             : controller status (done is a one-cycle pulse)
//   prod_hi, prod_lo       : 2*WIDTH-bit product, held until the next start
//   alu_a, alu_b, alu_op   : request into the shared ALU
//   alu_result             : combinational ALU result for the same cycle
// Modports:
//   master : datapath side (issues start, owns the ALU and returns alu_result)
//   slave  : the multiplier controller
// ----------------------------------------------------------------------------
interface alu_mul_seq_if
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = DATA_LEN
) ();

  logic              start;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  prod_hi;
  logic [WIDTH-1:0]  prod_lo;
  logic [WIDTH-1:0]  alu_a;
  logic [WIDTH-1:0]  alu_b;
  alu_opcode_t       alu_op;
  logic [WIDTH-1:0]  alu_result;

  modport master (
    output start, op_a, op_b, alu_result,
    input  busy, done, prod_hi, prod_lo, alu_a, alu_b, alu_op
  );

  modport slave (
    input  start, op_a, op_b, alu_result,
    output busy, done, prod_hi, prod_lo, alu_a, alu_b, alu_op
  );

endinterface

// File: rtl/alu_mul_seq.sv
// ----------------------------------------------------------------------------
// alu_mul_seq
// Multi-cycle unsigned shift-add multiplier controller. Each RUN cycle issues
// one ALU_ADD (acc + (mplr[0] ? mcand : 0)) on the shared ALU, then shifts
// {carry, sum, mplr} right by one. After WIDTH iterations {acc, mplr} holds
// the full 2*WIDTH-bit product.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : alu_mul_seq_if.slave (start/op_a/op_b in, busy/done/prod out,
//          alu_a/alu_b/alu_op out, alu_result in)
// Optional build macro:
//   MUL_ZERO_BYPASS_EN : a start with op_a==0 or op_b==0 skips RUN and goes
//                        straight to DONE with a zero product.
// ----------------------------------------------------------------------------
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = DATA_LEN,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  alu_mul_seq_if.slave bus
);

  mul_state_t         state_q, state_d;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   mplr_q;
  logic [WIDTH-1:0]   prod_hi_q;
  logic [WIDTH-1:0]   prod_lo_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept;
  logic               zero_op;
  logic               last_iter;
  logic               carry;
  logic [2*WIDTH-1:0] shifted;

  // A start is only heard when no iteration is in flight.
  assign accept    = bus.start && ((state_q == MUL_IDLE) || (state_q == MUL_DONE));
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_op = (bus.op_a == '0) || (bus.op_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // The ALU add wraps modulo 2^WIDTH; a wrapped sum is smaller than acc,
  // which recovers the carry-out that shifts into the top of acc.
  assign carry   = (bus.alu_result < acc_q);
  assign shifted = {carry, bus.alu_result, mplr_q[WIDTH-1:1]};

  assign bus.busy    = (state_q == MUL_RUN);
  assign bus.done    = (state_q == MUL_DONE);
  assign bus.prod_hi = prod_hi_q;
  assign bus.prod_lo = prod_lo_q;

  always_comb begin
    state_d    = state_q;
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    bus.alu_op = ALU_ADD;
    case (state_q)
      MUL_IDLE: begin
        if (accept) state_d = zero_op ? MUL_DONE : MUL_RUN;
      end
      MUL_RUN: begin
        bus.alu_a = acc_q;
        bus.alu_b = mplr_q[0] ? mcand_q : '0;
        if (last_iter) state_d = MUL_DONE;
      end
      MUL_DONE: begin
        if (accept) state_d = zero_op ? MUL_DONE : MUL_RUN;
        else        state_d = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  // Control and externally visible state: cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MUL_IDLE;
      mcand_q   <= '0;
      cnt_q     <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mcand_q <= bus.op_a;
        cnt_q   <= '0;
        if (zero_op) begin
          prod_hi_q <= '0;
          prod_lo_q <= '0;
        end
      end else if (state_q == MUL_RUN) begin
        cnt_q <= cnt_q + 1'b1;
        if (last_iter) begin
          prod_hi_q <= shifted[2*WIDTH-1:WIDTH];
          prod_lo_q <= shifted[WIDTH-1:0];
        end
      end
    end
  end

  // Working accumulator / multiplier shift register: always reloaded on an
  // accepted start, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_q  <= '0;
      mplr_q <= bus.op_b;
    end else if (state_q == MUL_RUN) begin
      acc_q  <= shifted[2*WIDTH-1:WIDTH];
      mplr_q <= shifted[WIDTH-1:0];
    end
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle unsigned multiplier controller that sequences the shared 32-bit ALU over its own operand/opcode/result port.
- Implements shift-add multiplication: one ALU_ADD per iteration; it produces a full 2×WIDTH product over WIDTH iterations.
- Sits beside the single-period datapath's ALU; the datapath issues a start and waits for done.
- Operand muxing into the shared ALU is owned by the datapath; this block only drives the alu_* request signals.

Parameters:
- WIDTH, `DATA_LEN (32): operand width and ALU width.
- CNT_W, $clog2(WIDTH)+1 (6): iteration counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- op_a  input  WIDTH  multiplicand; captured on accepted start.
- op_b  input  WIDTH  multiplier; captured on accepted start.
- busy  output  1  high while iterating (RUN).
- done  output  1  one-cycle pulse; product valid.
- prod_hi  output  WIDTH  upper half of the product; held until the next accepted start.
- prod_lo  output  WIDTH  lower half of the product; held until the next accepted start.
- alu_a  output  WIDTH  ALU operand a.
- alu_b  output  WIDTH  ALU operand b.
- alu_op  output  `ALU_OPCODE  ALU opcode.
- alu_result  input  WIDTH  combinational ALU result for the same cycle.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0; done=0; prod_hi=prod_lo=0; mcand=0; cnt=0.
- States: IDLE, RUN, DONE.
  - IDLE: if start, capture mcand=op_a, acc=0, mplr=op_b, cnt=0, then go to RUN.
  - RUN: one iteration per cycle.
  - DONE: lasts exactly one cycle, with done=1. If start is high in DONE, the start is accepted (same capture as IDLE) and the next state is RUN; otherwise the next state is IDLE.
- alu_* drive (combinational):
  - RUN: alu_a=acc; alu_b = mplr[0] ? mcand : 0; alu_op=`ALU_ADD.
  - IDLE and DONE: alu_a=0; alu_b=0; alu_op=`ALU_ADD.
- RUN iteration:
  - carry = (alu_result < acc), unsigned compare.
  - {acc, mplr} <= {carry, alu_result, mplr} >> 1.
  - cnt <= cnt+1.
  - When cnt==WIDTH-1, go to DONE and load prod_hi/prod_lo from the final shifted value.
- Latency: start sampled at edge T → busy=1 during cycles T+1..T+WIDTH → done=1 at cycle T+WIDTH+1 (T+33 for WIDTH=32).
- Boundary and concurrency rules:
  - start while busy: ignored, with no effect on operands or state.
  - op_a/op_b changing after acceptance: no effect.
  - busy and done are never high together.
  - rst mid-RUN: abort; on the next cycle all outputs are at reset values and no done is produced.
  - Arithmetic is unsigned modulo 2^WIDTH per add; the carry bit is never lost.
  - Maximum product (2^WIDTH-1)^2 must be exact.

Optional Feature:
- Macro: MUL_ZERO_BYPASS_EN.
- Defined: if the captured op_a==0 or op_b==0, IDLE/DONE go straight to DONE (skipping RUN). done pulses at T+1 with prod_hi=prod_lo=0; busy stays 0; the ALU is never exercised.
- Undefined: zero operands take the full WIDTH-cycle RUN, with done at T+WIDTH+1 and product 0.

Decomposition:
- Shared constants (`DATA_LEN, `ALU_OPCODE, `ALU_ADD) come from defines.v.
- New in defines.v: state encodings `MUL_IDLE=2'd0, `MUL_RUN=2'd1, `MUL_DONE=2'd2.
- No sub-module. The ALU stays external and is connected at the top level or in the bench.

Test Plan:
- op_a=3, op_b=5, start at T → busy high T+1..T+32; done at T+33; prod_hi=0, prod_lo=15; alu_op=`ALU_ADD throughout RUN.
- op_a=op_b=0xFFFFFFFF → prod_hi=0xFFFFFFFE, prod_lo=0x00000001 (checks the carry path).
- start pulsed again at T+10 with op_a=7, op_b=7 during the 3×5 run → ignored; result is still 15 at T+33.
- start held high in the DONE cycle with op_a=0x10000, op_b=0x10000 → new run accepted without an IDLE gap; prod_hi=1, prod_lo=0 exactly 33 cycles later.
- rst asserted at T+12 of a run → next cycle busy=0, done=0, prod=0, state IDLE; no done pulse afterwards.
- op_a=0, op_b=9: with MUL_ZERO_BYPASS_EN → done at T+1, busy never high, prod=0; without it → done at T+33, prod=0.
